// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller clocked by iclk.
// The tck/tms/tdi pins are synchronised and tck edges are detected.
// The 16-state TAP FSM is stepped on each detected tck rise.
// The FSM drives single-iclk capture/shift/update strobes for the IR and DR cell chains.
// Optional build macro JTAG_TRSTN_EN adds the trstn pin. While the synchronised trstn
// is low, the FSM is held in Test-Logic-Reset and all strobes are suppressed.
module jtag_tap_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       iclk,
   input  logic       resetn,
   input  logic       tck,
   input  logic       tms,
   input  logic       tdi,
`ifdef JTAG_TRSTN_EN
   input  logic       trstn,
`endif
   output logic       tdi_s,
   output logic [3:0] tap_state,
   output logic       tlr,
   output logic       shift_ir,
   output logic       clk_ir,
   output logic       update_ir,
   output logic       shift_dr,
   output logic       clk_dr,
   output logic       update_dr,
   output logic       ir_sel,
   output logic       tdo_en
);

   typedef enum logic [3:0] {
      TLR   = 4'hF,
      RTI   = 4'hC,
      SELDR = 4'h7,
      CAPDR = 4'h6,
      SHDR  = 4'h2,
      EX1DR = 4'h1,
      PSDR  = 4'h3,
      EX2DR = 4'h0,
      UPDDR = 4'h5,
      SELIR = 4'h4,
      CAPIR = 4'hE,
      SHIR  = 4'hA,
      EX1IR = 4'h9,
      PSIR  = 4'hB,
      EX2IR = 4'h8,
      UPDIR = 4'hD
   } tap_state_e;

   logic [SYNC_STAGES-1:0] tck_sync_q;
   logic [SYNC_STAGES-1:0] tms_sync_q;
   logic [SYNC_STAGES-1:0] tdi_sync_q;
   logic                   tck_s;
   logic                   tms_s;
   logic                   tdi_sync_s;

   logic                   tck_dly_q;
   logic                   tck_rise_q;
   logic                   tck_fall_q;
   logic                   tms_smp_q;
   logic                   tdi_s_q;
   logic                   rise_now;
   logic                   fall_now;

   logic                   trst_act;

   tap_state_e             state_q;
   tap_state_e             state_d;
   logic                   tdo_en_q;
   logic                   tdo_en_d;
   logic                   ir_sel_q;
   logic                   ir_sel_d;

   // Pin synchronisers: each pin passes through SYNC_STAGES flops.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         tck_sync_q <= '0;
         tms_sync_q <= '0;
         tdi_sync_q <= '0;
      end else begin
         tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], tck};
         tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], tms};
         tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], tdi};
      end
   end

   assign tck_s      = tck_sync_q[SYNC_STAGES-1];
   assign tms_s      = tms_sync_q[SYNC_STAGES-1];
   assign tdi_sync_s = tdi_sync_q[SYNC_STAGES-1];
   assign rise_now   = tck_s & ~tck_dly_q;
   assign fall_now   = ~tck_s & tck_dly_q;

   // Edge detection and pin sampling. tms/tdi are captured on the same edge
   // that raises tck_rise, so they hold the values seen at the tck rise.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         tck_dly_q  <= 1'b0;
         tck_rise_q <= 1'b0;
         tck_fall_q <= 1'b0;
         tms_smp_q  <= 1'b0;
         tdi_s_q    <= 1'b0;
      end else begin
         tck_dly_q  <= tck_s;
         tck_rise_q <= rise_now;
         tck_fall_q <= fall_now;
         if (rise_now) begin
            tms_smp_q <= tms_s;
            tdi_s_q   <= tdi_sync_s;
         end
      end
   end

`ifdef JTAG_TRSTN_EN
   logic [SYNC_STAGES-1:0] trst_sync_q;

   // trstn synchroniser: resetn asserts it asynchronously, and release is synchronous.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         trst_sync_q <= '0;
      end else begin
         trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], trstn};
      end
   end

   assign trst_act = ~trst_sync_q[SYNC_STAGES-1];
`else
   assign trst_act = 1'b0;
`endif

   // State, tdo enable and chain select registers.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= TLR;
         tdo_en_q <= 1'b0;
         ir_sel_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tdo_en_q <= tdo_en_d;
         ir_sel_q <= ir_sel_d;
      end
   end

   // Next-state logic for the TAP graph. It advances only on a tck rise; trst overrides.
   always_comb begin
      state_d = state_q;
      if (trst_act) begin
         state_d = TLR;
      end else if (tck_rise_q) begin
         case (state_q)
            TLR:     state_d = tms_smp_q ? TLR   : RTI;
            RTI:     state_d = tms_smp_q ? SELDR : RTI;
            SELDR:   state_d = tms_smp_q ? SELIR : CAPDR;
            CAPDR:   state_d = tms_smp_q ? EX1DR : SHDR;
            SHDR:    state_d = tms_smp_q ? EX1DR : SHDR;
            EX1DR:   state_d = tms_smp_q ? UPDDR : PSDR;
            PSDR:    state_d = tms_smp_q ? EX2DR : PSDR;
            EX2DR:   state_d = tms_smp_q ? UPDDR : SHDR;
            UPDDR:   state_d = tms_smp_q ? SELDR : RTI;
            SELIR:   state_d = tms_smp_q ? TLR   : CAPIR;
            CAPIR:   state_d = tms_smp_q ? EX1IR : SHIR;
            SHIR:    state_d = tms_smp_q ? EX1IR : SHIR;
            EX1IR:   state_d = tms_smp_q ? UPDIR : PSIR;
            PSIR:    state_d = tms_smp_q ? EX2IR : PSIR;
            EX2IR:   state_d = tms_smp_q ? UPDIR : SHIR;
            UPDIR:   state_d = tms_smp_q ? SELDR : RTI;
            default: state_d = TLR;
         endcase
      end
   end

   // Cell strobes and shift levels decoded from the current state. tdo_en and ir_sel
   // are updated on the tck fall.
   always_comb begin
      clk_ir    = 1'b0;
      clk_dr    = 1'b0;
      update_ir = 1'b0;
      update_dr = 1'b0;
      shift_ir  = 1'b0;
      shift_dr  = 1'b0;
      tdo_en_d  = tdo_en_q;
      ir_sel_d  = ir_sel_q;
      if (trst_act) begin
         tdo_en_d = 1'b0;
         ir_sel_d = 1'b0;
      end else begin
         shift_ir  = (state_q == SHIR);
         shift_dr  = (state_q == SHDR);
         clk_ir    = tck_rise_q & ((state_q == CAPIR) | (state_q == SHIR));
         clk_dr    = tck_rise_q & ((state_q == CAPDR) | (state_q == SHDR));
         update_ir = tck_fall_q & (state_q == UPDIR);
         update_dr = tck_fall_q & (state_q == UPDDR);
         if (tck_fall_q) begin
            tdo_en_d = (state_q == SHIR) | (state_q == SHDR);
            ir_sel_d = (state_q == SHIR) | (ir_sel_q & (state_q != SHDR));
         end
      end
   end

   assign tap_state = state_q;
   assign tlr       = (state_q == TLR);
   assign tdi_s     = tdi_s_q;
   assign tdo_en    = tdo_en_q;
   assign ir_sel    = ir_sel_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: self-checking bench for jtag_tap_ctrl.
// Expected TAP states are queued as tck cycles are driven and popped once the cycle settles.
// Strobe pulses are counted by a monitor sampling on the falling iclk edge.
// Define JTAG_TRSTN_EN to include the trstn scenario.
module tb_jtag_tap_ctrl;

   localparam int SYNC_STAGES = 2;

   localparam logic [3:0] S_TLR   = 4'hF;
   localparam logic [3:0] S_RTI   = 4'hC;
   localparam logic [3:0] S_SELDR = 4'h7;
   localparam logic [3:0] S_CAPDR = 4'h6;
   localparam logic [3:0] S_SHDR  = 4'h2;
   localparam logic [3:0] S_EX1DR = 4'h1;
   localparam logic [3:0] S_UPDDR = 4'h5;
   localparam logic [3:0] S_SELIR = 4'h4;
   localparam logic [3:0] S_CAPIR = 4'hE;
   localparam logic [3:0] S_SHIR  = 4'hA;
   localparam logic [3:0] S_EX1IR = 4'h9;
   localparam logic [3:0] S_PSIR  = 4'hB;
   localparam logic [3:0] S_EX2IR = 4'h8;
   localparam logic [3:0] S_UPDIR = 4'hD;

   logic       iclk   = 1'b0;
   logic       resetn = 1'b1;
   logic       tck    = 1'b0;
   logic       tms    = 1'b0;
   logic       tdi    = 1'b0;
`ifdef JTAG_TRSTN_EN
   logic       trstn  = 1'b1;
`endif
   logic       tdi_s;
   logic [3:0] tap_state;
   logic       tlr;
   logic       shift_ir;
   logic       clk_ir;
   logic       update_ir;
   logic       shift_dr;
   logic       clk_dr;
   logic       update_dr;
   logic       ir_sel;
   logic       tdo_en;

   int n_checks = 0;
   int n_fail   = 0;

   int cnt_clk_ir    = 0;
   int cnt_clk_ir_sh = 0;
   int cnt_clk_dr    = 0;
   int cnt_clk_dr_sh = 0;
   int cnt_upd_ir    = 0;
   int cnt_upd_dr    = 0;

   logic [3:0] exp_q[$];

   jtag_tap_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .iclk      (iclk),
      .resetn    (resetn),
      .tck       (tck),
      .tms       (tms),
      .tdi       (tdi),
`ifdef JTAG_TRSTN_EN
      .trstn     (trstn),
`endif
      .tdi_s     (tdi_s),
      .tap_state (tap_state),
      .tlr       (tlr),
      .shift_ir  (shift_ir),
      .clk_ir    (clk_ir),
      .update_ir (update_ir),
      .shift_dr  (shift_dr),
      .clk_dr    (clk_dr),
      .update_dr (update_dr),
      .ir_sel    (ir_sel),
      .tdo_en    (tdo_en)
   );

   always #5 iclk = ~iclk;

   // Strobe monitor, sampled away from the active clock edge.
   always @(negedge iclk) begin
      if (clk_ir)              cnt_clk_ir    <= cnt_clk_ir + 1;
      if (clk_ir && shift_ir)  cnt_clk_ir_sh <= cnt_clk_ir_sh + 1;
      if (clk_dr)              cnt_clk_dr    <= cnt_clk_dr + 1;
      if (clk_dr && shift_dr)  cnt_clk_dr_sh <= cnt_clk_dr_sh + 1;
      if (update_ir)           cnt_upd_ir    <= cnt_upd_ir + 1;
      if (update_dr)           cnt_upd_dr    <= cnt_upd_dr + 1;
   end

   task automatic tck_hi(input logic m, input logic d);
      @(negedge iclk);
      tms = m;
      tdi = d;
      @(negedge iclk);
      tck = 1'b1;
      repeat (8) @(negedge iclk);
   endtask

   task automatic tck_lo();
      tck = 1'b0;
      repeat (8) @(negedge iclk);
   endtask

   task automatic tck_cycle(input logic m, input logic d);
      tck_hi(m, d);
      tck_lo();
   endtask

   task automatic test_reset();
      logic [3:0] e;
      @(negedge iclk);
      resetn = 1'b0;
      repeat (3) @(negedge iclk);
      n_checks++;
      if (tap_state !== S_TLR) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", tap_state, S_TLR);
      end
      n_checks++;
      if (tlr !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_tlr: got %b expected 1", tlr);
      end
      n_checks++;
      if ({clk_ir, update_ir, clk_dr, update_dr, shift_ir, shift_dr} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b expected 000000",
                  {clk_ir, update_ir, clk_dr, update_dr, shift_ir, shift_dr});
      end
      n_checks++;
      if ({tdo_en, ir_sel, tdi_s} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_regs: tdo_en/ir_sel/tdi_s got %b expected 000", {tdo_en, ir_sel, tdi_s});
      end
      @(negedge iclk);
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(S_TLR);
         tck_cycle(1'b1, 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (tap_state !== e) begin
            n_fail++;
            $display("FAIL tlr_hold[%0d]: got %h expected %h", i, tap_state, e);
         end
      end
   endtask

   task automatic test_ir_scan();
      logic       tms_seq [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] st_seq  [5] = '{S_RTI, S_SELDR, S_SELIR, S_CAPIR, S_SHIR};
      logic       tdi_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [3:0] e;
      int c0, s0, u0;
      c0 = cnt_clk_ir;
      s0 = cnt_clk_ir_sh;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(st_seq[i]);
         tck_cycle(tms_seq[i], 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (tap_state !== e) begin
            n_fail++;
            $display("FAIL ir_path[%0d]: got %h expected %h", i, tap_state, e);
         end
      end
      n_checks++;
      if ((cnt_clk_ir - c0) !== 1 || (cnt_clk_ir_sh - s0) !== 0) begin
         n_fail++;
         $display("FAIL ir_capture: clk_ir pulses %0d (shifting %0d) expected 1 (0)",
                  cnt_clk_ir - c0, cnt_clk_ir_sh - s0);
      end
      n_checks++;
      if ({shift_ir, tdo_en, ir_sel} !== 3'b111) begin
         n_fail++;
         $display("FAIL ir_shift_levels: shift_ir/tdo_en/ir_sel got %b expected 111",
                  {shift_ir, tdo_en, ir_sel});
      end
      c0 = cnt_clk_ir;
      s0 = cnt_clk_ir_sh;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(S_SHIR);
         tck_cycle(1'b0, tdi_seq[i]);
         e = exp_q.pop_front();
         n_checks++;
         if (tap_state !== e || tdi_s !== tdi_seq[i]) begin
            n_fail++;
            $display("FAIL ir_shift[%0d]: state %h tdi_s %b expected %h %b",
                     i, tap_state, tdi_s, e, tdi_seq[i]);
         end
      end
      n_checks++;
      if ((cnt_clk_ir - c0) !== 4 || (cnt_clk_ir_sh - s0) !== 4) begin
         n_fail++;
         $display("FAIL ir_shift_pulses: got %0d (shifting %0d) expected 4 (4)",
                  cnt_clk_ir - c0, cnt_clk_ir_sh - s0);
      end
      c0 = cnt_clk_ir;
      u0 = cnt_upd_ir;
      exp_q.push_back(S_EX1IR);
      exp_q.push_back(S_UPDIR);
      for (int i = 0; i < 2; i++) begin
         tck_cycle(1'b1, 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (tap_state !== e) begin
            n_fail++;
            $display("FAIL ir_exit[%0d]: got %h expected %h", i, tap_state, e);
         end
      end
      n_checks++;
      if ((cnt_upd_ir - u0) !== 1 || (cnt_clk_ir - c0) !== 1) begin
         n_fail++;
         $display("FAIL ir_update: update_ir %0d clk_ir %0d expected 1 1",
                  cnt_upd_ir - u0, cnt_clk_ir - c0);
      end
      n_checks++;
      if ({tdo_en, ir_sel} !== 2'b01) begin
         n_fail++;
         $display("FAIL ir_after_update: tdo_en/ir_sel got %b expected 01", {tdo_en, ir_sel});
      end
      exp_q.push_back(S_RTI);
      tck_cycle(1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (tap_state !== e) begin
         n_fail++;
         $display("FAIL ir_to_rti: got %h expected %h", tap_state, e);
      end
   endtask

   task automatic test_dr_scan();
      logic       tms_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [3:0] st_seq  [5] = '{S_SELDR, S_CAPDR, S_SHDR, S_SHDR, S_SHDR};
      logic [3:0] e;
      int c0, s0, i0, u0;
      c0 = cnt_clk_dr;
      s0 = cnt_clk_dr_sh;
      i0 = cnt_clk_ir;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(st_seq[i]);
         tck_cycle(tms_seq[i], 1'b1);
         e = exp_q.pop_front();
         n_checks++;
         if (tap_state !== e) begin
            n_fail++;
            $display("FAIL dr_path[%0d]: got %h expected %h", i, tap_state, e);
         end
      end
      n_checks++;
      if ((cnt_clk_dr - c0) !== 3 || (cnt_clk_dr_sh - s0) !== 2 || (cnt_clk_ir - i0) !== 0) begin
         n_fail++;
         $display("FAIL dr_pulses: clk_dr %0d shifting %0d clk_ir %0d expected 3 2 0",
                  cnt_clk_dr - c0, cnt_clk_dr_sh - s0, cnt_clk_ir - i0);
      end
      n_checks++;
      if ({shift_dr, tdo_en, ir_sel} !== 3'b110) begin
         n_fail++;
         $display("FAIL dr_levels: shift_dr/tdo_en/ir_sel got %b expected 110",
                  {shift_dr, tdo_en, ir_sel});
      end
      exp_q.push_back(S_EX1DR);
      tck_hi(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (tap_state !== e || tdo_en !== 1'b1) begin
         n_fail++;
         $display("FAIL dr_exit_rise: state %h tdo_en %b expected %h 1", tap_state, tdo_en, e);
      end
      tck_lo();
      n_checks++;
      if ({tdo_en, ir_sel} !== 2'b00) begin
         n_fail++;
         $display("FAIL dr_exit_fall: tdo_en/ir_sel got %b expected 00", {tdo_en, ir_sel});
      end
      u0 = cnt_upd_dr;
      exp_q.push_back(S_UPDDR);
      tck_cycle(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (tap_state !== e || (cnt_upd_dr - u0) !== 1) begin
         n_fail++;
         $display("FAIL dr_update: state %h update_dr %0d expected %h 1", tap_state, cnt_upd_dr - u0, e);
      end
      exp_q.push_back(S_RTI);
      tck_cycle(1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (tap_state !== e) begin
         n_fail++;
         $display("FAIL dr_to_rti: got %h expected %h", tap_state, e);
      end
   endtask

   task automatic test_pause();
      logic       tms_seq [14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0] st_seq  [14] = '{S_SELDR, S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PSIR,
                                   S_PSIR, S_PSIR, S_PSIR, S_EX2IR, S_SHIR, S_SHIR,
                                   S_EX1IR, S_UPDIR};
      logic [3:0] e;
      int c0, s0;
      c0 = 0;
      s0 = 0;
      for (int i = 0; i < 14; i++) begin
         if (i == 6) c0 = cnt_clk_ir;
         if (i == 11) begin
            n_checks++;
            if ((cnt_clk_ir - c0) !== 0) begin
               n_fail++;
               $display("FAIL pause_no_clk: clk_ir %0d expected 0", cnt_clk_ir - c0);
            end
            s0 = cnt_clk_ir_sh;
         end
         exp_q.push_back(st_seq[i]);
         tck_cycle(tms_seq[i], 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (tap_state !== e) begin
            n_fail++;
            $display("FAIL pause_path[%0d]: got %h expected %h", i, tap_state, e);
         end
         if (i == 11) begin
            n_checks++;
            if ((cnt_clk_ir_sh - s0) !== 1) begin
               n_fail++;
               $display("FAIL pause_resume: shifting clk_ir %0d expected 1", cnt_clk_ir_sh - s0);
            end
         end
      end
      exp_q.push_back(S_RTI);
      tck_cycle(1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (tap_state !== e) begin
         n_fail++;
         $display("FAIL pause_to_rti: got %h expected %h", tap_state, e);
      end
   endtask

   task automatic test_reset_midscan();
      logic       tms_seq [3] = '{1'b1, 1'b0, 1'b0};
      logic [3:0] st_seq  [3] = '{S_SELDR, S_CAPDR, S_SHDR};
      logic [3:0] e;
      int u0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(st_seq[i]);
         tck_cycle(tms_seq[i], 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (tap_state !== e) begin
            n_fail++;
            $display("FAIL midscan_path[%0d]: got %h expected %h", i, tap_state, e);
         end
      end
      u0 = cnt_upd_dr;
      @(negedge iclk);
      resetn = 1'b0;
      #1;
      n_checks++;
      if (tap_state !== S_TLR || tlr !== 1'b1) begin
         n_fail++;
         $display("FAIL midscan_async: state %h tlr %b expected %h 1", tap_state, tlr, S_TLR);
      end
      @(negedge iclk);
      resetn = 1'b1;
      repeat (20) @(negedge iclk);
      n_checks++;
      if (tap_state !== S_TLR || (cnt_upd_dr - u0) !== 0 || tdo_en !== 1'b0) begin
         n_fail++;
         $display("FAIL midscan_after: state %h update_dr %0d tdo_en %b expected %h 0 0",
                  tap_state, cnt_upd_dr - u0, tdo_en, S_TLR);
      end
      exp_q.push_back(S_RTI);
      tck_cycle(1'b0, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if (tap_state !== e) begin
         n_fail++;
         $display("FAIL midscan_recover: got %h expected %h", tap_state, e);
      end
   endtask

`ifdef JTAG_TRSTN_EN
   task automatic test_trstn();
      logic       tms_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] st_seq  [4] = '{S_SELDR, S_SELIR, S_CAPIR, S_SHIR};
      logic [3:0] e;
      int u0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(st_seq[i]);
         tck_cycle(tms_seq[i], 1'b0);
         e = exp_q.pop_front();
         n_checks++;
         if (tap_state !== e) begin
            n_fail++;
            $display("FAIL trst_path[%0d]: got %h expected %h", i, tap_state, e);
         end
      end
      u0 = cnt_upd_ir;
      @(negedge iclk);
      trstn = 1'b0;
      repeat (SYNC_STAGES + 1) @(negedge iclk);
      n_checks++;
      if (tap_state !== S_TLR) begin
         n_fail++;
         $display("FAIL trst_force: got %h expected %h", tap_state, S_TLR);
      end
      @(negedge iclk);
      trstn = 1'b1;
      repeat (20) @(negedge iclk);
      n_checks++;
      if (tap_state !== S_TLR || tlr !== 1'b1 || (cnt_upd_ir - u0) !== 0) begin
         n_fail++;
         $display("FAIL trst_after: state %h tlr %b update_ir %0d expected %h 1 0",
                  tap_state, tlr, cnt_upd_ir - u0, S_TLR);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ir_scan();
      test_dr_scan();
      test_pause();
      test_reset_midscan();
`ifdef JTAG_TRSTN_EN
      test_trstn();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
